order_content_reader: RTL and testbench
=======================================

# order_content_reader

Sole owner of the single port of the 4096-entry, 793-bit order-content RAM in the router output-port-lookup path. It arbitrates write and read requests onto the RAM port, with writes taking priority. Each read record is serialized onto a 256-bit AXI4-Stream master as 4 beats for the downstream order-processing stage. The RAM instance sits beside this block; this block drives its address, data and write-enable ports and consumes its read data output.

## Interface
Parameters:
- DATA_WIDTH, 793, record width (RAM word)
- ADDR_WIDTH, 12, record index width (4096 entries)
- C_M_AXIS_DATA_WIDTH, 256, stream data width

Ports:
- axis_aclk  in  1  sole clock; RAM shares it
- axis_resetn  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_addr  in  12  write index
- wr_data  in  793  write record
- rd_valid  in  1  read request
- rd_ready  out  1  read accepted when rd_valid & rd_ready
- rd_addr  in  12  read index
- ram_addr  out  12  to RAM address port
- ram_din  out  793  to RAM write-data port
- ram_we  out  1  to RAM write enable
- ram_dout  in  793  from RAM read-data port; registered in RAM, 1-cycle latency, write-first
- m_axis_tdata  out  256  record beat
- m_axis_tkeep  out  32  byte enables
- m_axis_tuser  out  12  record index, constant across all 4 beats
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1  high on beat 3 only

## Operation
- FSM states: IDLE, RD_WAIT, RD_CAP, SEND.
- wr_ready = (state==IDLE).
- rd_ready = (state==IDLE) & ~wr_valid. A pending write always wins.
- Write accept in IDLE:
  - Register ram_we=1, ram_addr=wr_addr, ram_din=wr_data.
  - Stay in IDLE.
  - ram_we clears on the next edge unless another write is accepted. Back-to-back writes at 1 per cycle are allowed.
- Read accept in IDLE:
  - Register ram_we=0, ram_addr=rd_addr, tuser_reg=rd_addr.
  - Go to RD_WAIT.
- RD_WAIT → RD_CAP unconditionally. The RAM samples the address on this edge.
- RD_CAP:
  - ram_dout is valid. On the edge, load the 793-bit record into a 1024-bit buffer, zero-extended.
  - Set beat=0 and go to SEND.
- SEND:
  - m_axis_tvalid=1.
  - tdata = buffer[256*beat +: 256].
  - Beats 0–2: tkeep=0xFFFFFFFF. Beat 3: tkeep=0x0000000F, tdata bits [255:25]=0.
  - tlast=(beat==3).
  - On tvalid & tready: beat++. At beat 3, go to IDLE and drop tvalid.
  - While tready=0, tdata/tkeep/tlast/tuser stay stable and tvalid stays high.
- ram_addr and ram_din hold their last value when idle. ram_we is 0 outside write-accept cycles.
- Address arithmetic: none; indices 0..4095 pass through unchanged. The 2-bit beat counter never exceeds 3.
- Reset (any state):
  - state=IDLE, beat=0.
  - ram_we=0, ram_addr=0, ram_din=0.
  - m_axis_tvalid=0, tlast=0, tdata=0, tkeep=0, tuser=0.
  - A stream in progress is abandoned: no tlast is emitted and no partial record resumes after reset.
  - A write already registered but not yet sampled is dropped.

## Timing
- Write accepted at edge N: ram_we/addr/din are visible after N, and the RAM commits the write at edge N+1.
- Read accepted at edge N:
  - RD_WAIT after N; the RAM samples at N+1.
  - RD_CAP after N+1; the buffer loads at N+2.
  - Beat 0 tvalid is visible after N+2.
- With tready held high, beats complete at edges N+3..N+6. IDLE follows N+6, and the next read can be accepted at N+7. Minimum read period is 7 cycles.
- Write at N then read of the same index at N+1: the RAM commits at N+1, reads at N+2, and the new data is returned.

## Test plan
- Write index 5 = pattern {793 bits of 0xA5 repeating}; read 5.
  - Expect 4 beats equal to slices [255:0], [511:256], [767:512], {231'b0, [792:768]}.
  - tkeep FFFFFFFF×3 then 0000000F; tuser=5; tlast only on beat 3; first tvalid 2 cycles after read accept.
- wr_valid and rd_valid both high in IDLE: write accepted, rd_ready=0. Read accepted the next cycle and returns the just-written data.
- tready toggles 1,0,0,1,0,1,1 during SEND: beats never skipped or duplicated, and data stays stable while stalled.
- Write index 4095 and index 0 with distinct data, then read both: correct records, no aliasing.
- Assert axis_resetn low mid-SEND after beat 1: tvalid drops immediately (async). After release, only new requests produce output, and IDLE accepts a read on the first cycle.
- 16 back-to-back writes to indices 0..15, then reads in reverse order: every record matches and ram_we pulses exactly 16 cycles.

Source files
------------

// File: rtl/order_content_reader_if.sv
// Signal bundle between order_content_reader and its neighbours: write/read request
// ports, the order-content RAM port, and the AXI4-Stream master toward order processing.
interface order_content_reader_if #(
   parameter int DATA_WIDTH          = 793,
   parameter int ADDR_WIDTH          = 12,
   parameter int C_M_AXIS_DATA_WIDTH = 256
);
   logic                               wr_valid;
   logic                               wr_ready;
   logic [ADDR_WIDTH-1:0]              wr_addr;
   logic [DATA_WIDTH-1:0]              wr_data;
   logic                               rd_valid;
   logic                               rd_ready;
   logic [ADDR_WIDTH-1:0]              rd_addr;
   logic [ADDR_WIDTH-1:0]              ram_addr;
   logic [DATA_WIDTH-1:0]              ram_din;
   logic                               ram_we;
   logic [DATA_WIDTH-1:0]              ram_dout;
   logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata;
   logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep;
   logic [ADDR_WIDTH-1:0]              m_axis_tuser;
   logic                               m_axis_tvalid;
   logic                               m_axis_tready;
   logic                               m_axis_tlast;

   modport master (
      input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_dout, m_axis_tready,
      output wr_ready, rd_ready, ram_addr, ram_din, ram_we,
             m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast
   );

   modport slave (
      output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_dout, m_axis_tready,
      input  wr_ready, rd_ready, ram_addr, ram_din, ram_we,
             m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast
   );
endinterface

// File: rtl/order_content_reader.sv
// Single-port owner of the order-content RAM: writes win arbitration, and each read
// record is streamed out as four 256-bit AXI4-Stream beats.
module order_content_reader #(
   parameter int DATA_WIDTH          = 793,
   parameter int ADDR_WIDTH          = 12,
   parameter int C_M_AXIS_DATA_WIDTH = 256
) (
   input logic                    axis_aclk,
   input logic                    axis_resetn,
   order_content_reader_if.master bus
);
   localparam int BEATS      = 4;
   localparam int BUF_W      = BEATS * C_M_AXIS_DATA_WIDTH;
   localparam int KEEP_W     = C_M_AXIS_DATA_WIDTH / 8;
   localparam int LAST_BYTES = (DATA_WIDTH - (BEATS - 1) * C_M_AXIS_DATA_WIDTH + 7) / 8;
   localparam logic [KEEP_W-1:0] FULL_KEEP = '1;
   localparam logic [KEEP_W-1:0] LAST_KEEP = FULL_KEEP >> (KEEP_W - LAST_BYTES);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAP, SEND} state_t;

   state_t          state;
   logic [1:0]      beat;
   logic [BUF_W-1:0] record_buf;

   function automatic logic [BUF_W-1:0] zero_extend(input logic [DATA_WIDTH-1:0] rec);
      return BUF_W'(rec);
   endfunction

   function automatic logic [C_M_AXIS_DATA_WIDTH-1:0] beat_slice(input logic [BUF_W-1:0] rec,
                                                                 input logic [1:0]      idx);
      return rec[int'(idx) * C_M_AXIS_DATA_WIDTH +: C_M_AXIS_DATA_WIDTH];
   endfunction

   assign bus.wr_ready = (state == IDLE);
   assign bus.rd_ready = (state == IDLE) && !bus.wr_valid;

   // The record buffer is pure data and carries no reset; it is only read in SEND.
   always_ff @(posedge axis_aclk) begin
      if (state == RD_CAP) record_buf <= zero_extend(bus.ram_dout);
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state             <= IDLE;
         beat              <= 2'd0;
         bus.ram_we        <= 1'b0;
         bus.ram_addr      <= '0;
         bus.ram_din       <= '0;
         bus.m_axis_tvalid <= 1'b0;
         bus.m_axis_tlast  <= 1'b0;
         bus.m_axis_tdata  <= '0;
         bus.m_axis_tkeep  <= '0;
         bus.m_axis_tuser  <= '0;
      end else begin
         bus.ram_we <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.wr_valid) begin
                  bus.ram_we   <= 1'b1;
                  bus.ram_addr <= bus.wr_addr;
                  bus.ram_din  <= bus.wr_data;
               end else if (bus.rd_valid) begin
                  bus.ram_addr     <= bus.rd_addr;
                  bus.m_axis_tuser <= bus.rd_addr;
                  state            <= RD_WAIT;
               end
            end
            RD_WAIT: state <= RD_CAP;
            RD_CAP: begin
               // Beat 0 comes straight from the RAM output; the buffer loads on this same edge.
               beat              <= 2'd0;
               bus.m_axis_tvalid <= 1'b1;
               bus.m_axis_tdata  <= beat_slice(zero_extend(bus.ram_dout), 2'd0);
               bus.m_axis_tkeep  <= FULL_KEEP;
               bus.m_axis_tlast  <= 1'b0;
               state             <= SEND;
            end
            SEND: begin
               if (bus.m_axis_tready) begin
                  if (beat == 2'd3) begin
                     beat              <= 2'd0;
                     bus.m_axis_tvalid <= 1'b0;
                     bus.m_axis_tlast  <= 1'b0;
                     state             <= IDLE;
                  end else begin
                     beat             <= beat + 2'd1;
                     bus.m_axis_tdata <= beat_slice(record_buf, beat + 2'd1);
                     bus.m_axis_tkeep <= (beat == 2'd2) ? LAST_KEEP : FULL_KEEP;
                     bus.m_axis_tlast <= (beat == 2'd2);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_order_content_reader.sv
// Directed bench for order_content_reader with a behavioural write-first RAM and a
// beat scoreboard fed on read accept and drained by the stream monitor.
module tb_order_content_reader;
   typedef struct packed {
      logic [255:0] data;
      logic [31:0]  keep;
      logic [11:0]  user;
      logic         last;
   } beat_t;

   logic clk = 1'b0;
   logic rstn;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   we_cnt   = 0;
   beat_t exp_q[$];
   logic [792:0] shadow [0:4095];
   logic [792:0] ram_mem [0:4095];

   order_content_reader_if bus ();

   order_content_reader dut (
      .axis_aclk   (clk),
      .axis_resetn (rstn),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // Write-first RAM with one cycle of read latency
   always @(posedge clk) begin
      if (bus.ram_we) begin
         ram_mem[bus.ram_addr] <= bus.ram_din;
         bus.ram_dout          <= bus.ram_din;
      end else begin
         bus.ram_dout <= ram_mem[bus.ram_addr];
      end
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [792:0] rand_rec();
      logic [799:0] t;
      for (int i = 0; i < 25; i++) t[i*32 +: 32] = $urandom;
      return t[792:0];
   endfunction

   task automatic push_expected(input logic [11:0] a);
      logic [1023:0] ext;
      beat_t b;
      ext = {231'b0, shadow[a]};
      for (int i = 0; i < 4; i++) begin
         b.data = ext[i*256 +: 256];
         b.keep = (i == 3) ? 32'h0000000F : 32'hFFFFFFFF;
         b.user = a;
         b.last = (i == 3);
         exp_q.push_back(b);
      end
   endtask

   always @(negedge clk) begin
      if (bus.ram_we) we_cnt++;
      if (rstn && bus.m_axis_tvalid) begin
         if (exp_q.size() == 0) begin
            check("spurious_tvalid", 256'(bus.m_axis_tvalid), 256'd0);
         end else begin
            check("tdata", bus.m_axis_tdata, exp_q[0].data);
            check("tkeep", 256'(bus.m_axis_tkeep), 256'(exp_q[0].keep));
            check("tuser", 256'(bus.m_axis_tuser), 256'(exp_q[0].user));
            check("tlast", 256'(bus.m_axis_tlast), 256'(exp_q[0].last));
            if (bus.m_axis_tready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic do_write(input logic [11:0] a, input logic [792:0] d);
      int n;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = a;
      bus.wr_data  = d;
      n = 0;
      @(negedge clk);
      while (!bus.wr_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("wr_ready", 256'(bus.wr_ready), 256'd1);
      @(posedge clk);
      shadow[a] = d;
      #1 bus.wr_valid = 1'b0;
   endtask

   task automatic do_read(input logic [11:0] a);
      int n;
      bus.rd_valid = 1'b1;
      bus.rd_addr  = a;
      n = 0;
      @(negedge clk);
      while (!bus.rd_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("rd_ready", 256'(bus.rd_ready), 256'd1);
      push_expected(a);
      @(posedge clk);
      #1 bus.rd_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !bus.m_axis_tvalid) break;
      end
      check("drain_left", 256'(exp_q.size()), 256'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [799:0] a5_full;
      logic [792:0] pat, d7;
      logic [6:0]   tr_pat;
      int           n;

      rstn              = 1'b0;
      bus.wr_valid      = 1'b0;
      bus.wr_addr       = '0;
      bus.wr_data       = '0;
      bus.rd_valid      = 1'b0;
      bus.rd_addr       = '0;
      bus.m_axis_tready = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_tvalid", 256'(bus.m_axis_tvalid), 256'd0);
      check("rst_tlast", 256'(bus.m_axis_tlast), 256'd0);
      check("rst_tdata", bus.m_axis_tdata, 256'd0);
      check("rst_tkeep", 256'(bus.m_axis_tkeep), 256'd0);
      check("rst_tuser", 256'(bus.m_axis_tuser), 256'd0);
      check("rst_ram_we", 256'(bus.ram_we), 256'd0);
      check("rst_ram_addr", 256'(bus.ram_addr), 256'd0);
      check("rst_ram_din", bus.ram_din[255:0], 256'd0);
      check("rst_wr_ready", 256'(bus.wr_ready), 256'd1);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // A5 pattern at index 5, then read back with latency check
      a5_full = {100{8'hA5}};
      pat     = a5_full[792:0];
      do_write(12'd5, pat);
      check("wr_ram_we", 256'(bus.ram_we), 256'd1);
      check("wr_ram_addr", 256'(bus.ram_addr), 256'd5);
      check("wr_ram_din", bus.ram_din[255:0], pat[255:0]);
      do_read(12'd5);
      check("ram_we_clear", 256'(bus.ram_we), 256'd0);
      @(negedge clk);
      check("lat_rd_wait", 256'(bus.m_axis_tvalid), 256'd0);
      @(negedge clk);
      check("lat_rd_cap", 256'(bus.m_axis_tvalid), 256'd0);
      @(negedge clk);
      check("lat_beat0", 256'(bus.m_axis_tvalid), 256'd1);
      drain();

      // Simultaneous write and read: write wins, read follows and sees new data
      d7           = rand_rec();
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 12'd7;
      bus.wr_data  = d7;
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 12'd7;
      @(negedge clk);
      check("both_wr_ready", 256'(bus.wr_ready), 256'd1);
      check("both_rd_ready", 256'(bus.rd_ready), 256'd0);
      @(posedge clk);
      shadow[7] = d7;
      #1 bus.wr_valid = 1'b0;
      @(negedge clk);
      check("after_wr_rd_ready", 256'(bus.rd_ready), 256'd1);
      push_expected(12'd7);
      @(posedge clk);
      #1 bus.rd_valid = 1'b0;
      drain();

      // Backpressure pattern 1,0,0,1,0,1,1 during SEND
      bus.m_axis_tready = 1'b0;
      do_read(12'd5);
      n = 0;
      while (!bus.m_axis_tvalid && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      check("bp_tvalid_seen", 256'(bus.m_axis_tvalid), 256'd1);
      tr_pat = 7'b1101001;
      for (int i = 0; i < 7; i++) begin
         bus.m_axis_tready = tr_pat[i];
         @(posedge clk);
         #1;
      end
      bus.m_axis_tready = 1'b1;
      check("bp_beats_left", 256'(exp_q.size()), 256'd0);
      drain();

      // Extreme indices must not alias
      do_write(12'd4095, rand_rec());
      do_write(12'd0, rand_rec());
      do_read(12'd4095);
      drain();
      do_read(12'd0);
      drain();

      // Reset mid-SEND after beat 1 completes
      do_read(12'd4095);
      n = 0;
      while (exp_q.size() != 2 && n < 30) begin
         @(posedge clk);
         #1 n++;
      end
      check("mid_send_beats_left", 256'(exp_q.size()), 256'd2);
      rstn = 1'b0;
      #1;
      check("async_rst_tvalid", 256'(bus.m_axis_tvalid), 256'd0);
      check("async_rst_tlast", 256'(bus.m_axis_tlast), 256'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rstn         = 1'b1;
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 12'd0;
      #1;
      check("post_rst_rd_ready", 256'(bus.rd_ready), 256'd1);
      push_expected(12'd0);
      @(posedge clk);
      #1 bus.rd_valid = 1'b0;
      drain();

      // 16 back-to-back writes, then reverse-order reads
      we_cnt       = 0;
      bus.wr_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus.wr_addr = 12'(i);
         bus.wr_data = rand_rec();
         @(negedge clk);
         check("b2b_wr_ready", 256'(bus.wr_ready), 256'd1);
         @(posedge clk);
         shadow[i] = bus.wr_data;
         #1;
      end
      bus.wr_valid = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         do_read(12'(i));
         drain();
      end
      check("ram_we_pulses", 256'(we_cnt), 256'd16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
